// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : seg7_pkg                                                     |
// | Description : Shared constants for the seven-segment scan driver: the      |
// |               16-entry active-low gfedcba hex encoding table and the       |
// |               all-segments-off pattern.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package seg7_pkg;

  // All segments dark (active-low lines held high).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Hex glyphs 0..F, active-low, bit order gfedcba.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : seg7_scan_driver_if                                          |
// | Description : Frame-load and display-drive signals of the scan driver.     |
// |   data        4*2**N  hex nibble per digit (digit k = data[4k+3:4k])       |
// |   dp          2**N    decimal point per digit, 1 = lit                     |
// |   digit_en    2**N    per-digit enable, 0 blanks the digit                 |
// |   load        1       one-cycle strobe capturing data/dp/digit_en          |
// |   pending     1       captured frame waiting for the frame boundary        |
// |   sel         N       digit index to the anode decoder                     |
// |   sel_en      1       anode decoder enable                                 |
// |   seg         7       segments gfedcba, active-low                         |
// |   seg_dp      1       decimal point, active-low                            |
// |   frame_start 1       one-cycle pulse at the start of slot 0               |
// |   master: frame source side; slave: scan driver side.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface seg7_scan_driver_if #(
  parameter int N = 3
);
  logic [4*(2**N)-1:0] data;
  logic [(2**N)-1:0]   dp;
  logic [(2**N)-1:0]   digit_en;
  logic                load;
  logic                pending;
  logic [N-1:0]        sel;
  logic                sel_en;
  logic [6:0]          seg;
  logic                seg_dp;
  logic                frame_start;

  modport master (
    output data, dp, digit_en, load,
    input  pending, sel, sel_en, seg, seg_dp, frame_start
  );

  modport slave (
    input  data, dp, digit_en, load,
    output pending, sel, sel_en, seg, seg_dp, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/seg7_encode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_encode                                                  |
// | Description : Combinational hex nibble to active-low gfedcba segments.     |
// |   nibble  in   4  hex value                                                |
// |   seg     out  7  active-low segment pattern                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_encode (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  import seg7_pkg::*;

  assign seg = SEG_LUT[nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_scan_driver                                             |
// | Description : Time-multiplexed scan driver for a 2**N-digit common-anode   |
// |               seven-segment display. Double-buffered frame, fixed slot     |
// |               rate with a leading blank interval, registered outputs.      |
// |   clk    in  1  system clock                                               |
// |   rst_n  in  1  asynchronous active-low reset                              |
// |   bus    slave modport of seg7_scan_driver_if (load side + display side)   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_scan_driver #(
  parameter int N        = 3,
  parameter int PRESCALE = 100000,
  parameter int BLANK    = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);
  import seg7_pkg::*;

  localparam int             DIGITS    = 2**N;
  localparam int             DW        = 4*DIGITS;
  localparam int             TW        = $clog2(PRESCALE);
  localparam logic [TW-1:0]  TICK_LAST = TW'(PRESCALE-1);
  localparam logic [TW-1:0]  BLANK_T   = TW'(BLANK);
  localparam logic [N-1:0]   IDX_LAST  = '1;

  // Counters
  logic [TW-1:0]     tick_q, tick_d;
  logic [N-1:0]      idx_q, idx_d;
  // Active and pending frame buffers
  logic [DW-1:0]     act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0] act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic              pend_flag_q, pend_flag_d;
  // Output registers
  logic [N-1:0]      sel_q, sel_d;
  logic              sel_en_q, sel_en_d;
  logic [6:0]        seg_q, seg_d;
  logic              seg_dp_q, seg_dp_d;
  logic              frame_start_q, frame_start_d;

  logic              w_tick_last;
  logic              w_boundary;
  logic              w_blank;
  logic              w_show;
  logic [3:0]        w_nibble;
  logic [6:0]        w_seg_enc;

  assign w_nibble = act_data_q[{idx_q, 2'b00} +: 4];

  seg7_encode u_encode (
    .nibble (w_nibble),
    .seg    (w_seg_enc)
  );

  always_comb begin
    w_tick_last = (tick_q == TICK_LAST);
    w_boundary  = w_tick_last && (idx_q == IDX_LAST);
    tick_d      = w_tick_last ? '0 : tick_q + 1'b1;
    idx_d       = w_tick_last ? idx_q + 1'b1 : idx_q;

    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    pend_flag_d = pend_flag_q;

    if (w_boundary) begin
      // A load coinciding with the boundary bypasses the pending buffer
      // and supersedes whatever was waiting there.
      if (bus.load) begin
        act_data_d = bus.data;
        act_dp_d   = bus.dp;
        act_en_d   = bus.digit_en;
      end else if (pend_flag_q) begin
        act_data_d = pend_data_q;
        act_dp_d   = pend_dp_q;
        act_en_d   = pend_en_q;
      end
      pend_flag_d = 1'b0;
    end else if (bus.load) begin
      pend_data_d = bus.data;
      pend_dp_d   = bus.dp;
      pend_en_d   = bus.digit_en;
      pend_flag_d = 1'b1;
    end

    // Outputs are computed from the current state and registered, giving
    // one cycle of latency relative to tick/idx/active buffer.
    w_blank       = (tick_q < BLANK_T);
    w_show        = !w_blank && act_en_q[idx_q];
    sel_d         = idx_q;
    sel_en_d      = w_show;
    seg_d         = w_show ? w_seg_enc : SEG_OFF;
    seg_dp_d      = !(w_show && act_dp_q[idx_q]);
    frame_start_d = (tick_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q        <= '0;
      idx_q         <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_en_q      <= '0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_en_q     <= '0;
      pend_flag_q   <= 1'b0;
      sel_q         <= '0;
      sel_en_q      <= 1'b0;
      seg_q         <= SEG_OFF;
      seg_dp_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      idx_q         <= idx_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      act_en_q      <= act_en_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_en_q     <= pend_en_d;
      pend_flag_q   <= pend_flag_d;
      sel_q         <= sel_d;
      sel_en_q      <= sel_en_d;
      seg_q         <= seg_d;
      seg_dp_q      <= seg_dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.pending     = pend_flag_q;
  assign bus.sel         = sel_q;
  assign bus.sel_en      = sel_en_q;
  assign bus.seg         = seg_q;
  assign bus.seg_dp      = seg_dp_q;
  assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg7_scan_driver                                          |
// | Description : Directed self-checking bench for seg7_scan_driver with       |
// |               N=3, PRESCALE=8, BLANK=2 (64-cycle frames). Outputs are      |
// |               sampled on the falling edge; cycle k of a frame is the       |
// |               falling edge where frame_start is seen (k=0) plus k.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_driver;
  localparam int N        = 3;
  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_driver_if #(.N(N)) bus();

  seg7_scan_driver #(.N(N), .PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Advance to the falling edge where frame_start is high (k = 0).
  task automatic wait_frame();
    for (int i = 0; i < 200; i++) begin
      if (bus.frame_start === 1'b1) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL wait_frame: frame_start not seen within 200 cycles");
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] en, input logic [7:0] p);
    bus.data = d; bus.digit_en = en; bus.dp = p; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    bus.data = 32'hDEADBEEF; bus.digit_en = 8'hFF; bus.dp = 8'hFF; bus.load = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7f", bus.seg); end
    checks++; if (bus.sel_en !== 1'b0) begin errors++; $display("FAIL reset_sel_en got %b exp 0", bus.sel_en); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", bus.pending); end
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b exp 0", bus.frame_start); end
    checks++; if (bus.seg_dp !== 1'b1) begin errors++; $display("FAIL reset_seg_dp got %b exp 1", bus.seg_dp); end
    checks++; if (bus.sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", bus.sel); end
    rst_n = 1'b1; bus.load = 1'b0;
    @(negedge clk);
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL first_frame_start got %b exp 1", bus.frame_start); end
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      checks++;
      if (bus.frame_start !== (i == 64)) begin
        errors++; $display("FAIL frame_start_period k=%0d got %b exp %b", i, bus.frame_start, (i == 64));
      end
      checks++;
      if (bus.seg !== 7'h7F || bus.sel_en !== 1'b0) begin
        errors++; $display("FAIL dark_after_reset k=%0d got seg=%h sel_en=%b exp 7f/0", i, bus.seg, bus.sel_en);
      end
    end
  endtask

  task automatic test_scan_order();
    logic [6:0] e_seg;
    wait_frame();
    do_load(32'h76543210, 8'hFF, 8'h01);
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL scan_pending got %b exp 1", bus.pending); end
    wait_frame();
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL scan_pending_clear got %b exp 0", bus.pending); end
    for (int c = 0; c < 64; c++) begin
      e_seg = (c % 8 >= 2) ? exp_seg(c / 8) : 7'h7F;
      checks++; if (bus.sel !== 3'(c / 8)) begin errors++; $display("FAIL scan_sel c=%0d got %0d exp %0d", c, bus.sel, c / 8); end
      checks++; if (bus.sel_en !== (c % 8 >= 2)) begin errors++; $display("FAIL scan_sel_en c=%0d got %b exp %b", c, bus.sel_en, (c % 8 >= 2)); end
      checks++; if (bus.seg !== e_seg) begin errors++; $display("FAIL scan_seg c=%0d got %h exp %h", c, bus.seg, e_seg); end
      checks++; if (bus.seg_dp !== !((c % 8 >= 2) && (c / 8 == 0))) begin
        errors++; $display("FAIL scan_seg_dp c=%0d got %b exp %b", c, bus.seg_dp, !((c % 8 >= 2) && (c / 8 == 0)));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_double_buffer();
    logic seen79;
    seen79 = 1'b0;
    wait_frame();
    repeat (10) @(negedge clk);
    do_load(32'h11111111, 8'hFF, 8'h00);
    repeat (7) @(negedge clk);
    do_load(32'h22222222, 8'hFF, 8'h00);
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL dbuf_pending_k19 got %b exp 1", bus.pending); end
    repeat (43) @(negedge clk);
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL dbuf_pending_k62 got %b exp 1", bus.pending); end
    @(negedge clk);
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL dbuf_pending_k63 got %b exp 0", bus.pending); end
    @(negedge clk);
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL dbuf_frame_start got %b exp 1", bus.frame_start); end
    for (int c = 0; c < 64; c++) begin
      if (bus.seg === 7'h79) seen79 = 1'b1;
      if (c % 8 >= 2) begin
        checks++; if (bus.seg !== 7'h24) begin errors++; $display("FAIL dbuf_seg c=%0d got %h exp 24", c, bus.seg); end
      end
      @(negedge clk);
    end
    checks++; if (seen79 !== 1'b0) begin errors++; $display("FAIL dbuf_no79 got seen=%b exp 0", seen79); end
  endtask

  task automatic test_boundary_load();
    wait_frame();
    repeat (62) @(negedge clk);
    do_load(32'hFFFFFFFF, 8'hFF, 8'h00);
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL bload_pending_k63 got %b exp 0", bus.pending); end
    @(negedge clk);
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL bload_frame_start got %b exp 1", bus.frame_start); end
    for (int c = 0; c < 64; c++) begin
      if (c % 8 >= 2) begin
        checks++; if (bus.seg !== 7'h0E) begin errors++; $display("FAIL bload_seg c=%0d got %h exp 0e", c, bus.seg); end
      end
      checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL bload_pending c=%0d got %b exp 0", c, bus.pending); end
      @(negedge clk);
    end
  endtask

  task automatic test_digit_disable();
    logic       e_show;
    logic [6:0] e_seg;
    wait_frame();
    do_load(32'h76543210, 8'b1010_1010, 8'hFF);
    wait_frame();
    for (int c = 0; c < 64; c++) begin
      e_show = ((c / 8) % 2 == 1) && (c % 8 >= 2);
      e_seg  = e_show ? exp_seg(c / 8) : 7'h7F;
      checks++; if (bus.sel_en !== e_show) begin errors++; $display("FAIL dis_sel_en c=%0d got %b exp %b", c, bus.sel_en, e_show); end
      checks++; if (bus.seg !== e_seg) begin errors++; $display("FAIL dis_seg c=%0d got %h exp %h", c, bus.seg, e_seg); end
      checks++; if (bus.seg_dp !== !e_show) begin errors++; $display("FAIL dis_seg_dp c=%0d got %b exp %b", c, bus.seg_dp, !e_show); end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    wait_frame();
    repeat (30) @(negedge clk);
    do_load(32'h88888888, 8'hFF, 8'h00);
    repeat (11) @(negedge clk);
    // k=42: slot 5, show phase, digit 5 enabled by the previous frame.
    checks++; if (bus.sel_en !== 1'b1 || bus.seg !== 7'h12) begin
      errors++; $display("FAIL arst_pre got sel_en=%b seg=%h exp 1/12", bus.sel_en, bus.seg);
    end
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL arst_pre_pending got %b exp 1", bus.pending); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL arst_seg got %h exp 7f", bus.seg); end
    checks++; if (bus.sel_en !== 1'b0) begin errors++; $display("FAIL arst_sel_en got %b exp 0", bus.sel_en); end
    checks++; if (bus.sel !== 3'd0) begin errors++; $display("FAIL arst_sel got %0d exp 0", bus.sel); end
    checks++; if (bus.seg_dp !== 1'b1) begin errors++; $display("FAIL arst_seg_dp got %b exp 1", bus.seg_dp); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL arst_pending got %b exp 0", bus.pending); end
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL arst_frame_start got %b exp 0", bus.frame_start); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.frame_start !== 1'b1 || bus.sel !== 3'd0) begin
      errors++; $display("FAIL arst_restart got frame_start=%b sel=%0d exp 1/0", bus.frame_start, bus.sel);
    end
    // Two full frames dark: the discarded pending frame must never surface.
    for (int c = 0; c < 128; c++) begin
      checks++;
      if (bus.sel_en !== 1'b0 || bus.seg !== 7'h7F) begin
        errors++; $display("FAIL arst_dark c=%0d got sel_en=%b seg=%h exp 0/7f", c, bus.sel_en, bus.seg);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.data = '0; bus.dp = '0; bus.digit_en = '0; bus.load = 1'b0;
    test_reset();
    test_scan_order();
    test_double_buffer();
    test_boundary_load();
    test_digit_disable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed scan driver for the board's 2**N-digit common-anode seven-segment display. Holds a double-buffered frame of hex digits, steps a digit index at a fixed slot rate with a blanking interval, and drives the downstream anode decoder (`sel`, `sel_en`) and the shared active-low segment lines. It sits between the status/video-call telemetry logic that loads frames and the anode decoder that produces the anode lines.

## Interface
- `N`, 3: digit-select width; the display has 2**N digits.
- `PRESCALE`, 100000: clock cycles per digit slot; must be at least 2.
- `BLANK`, 1000: cycles at the start of each slot with all segments and anodes off; 0 ≤ BLANK < PRESCALE.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `data`  in  4*2**N  hex nibble per digit; digit k is `data[4k+3:4k]`.
- `dp`  in  2**N  decimal point per digit; 1 = lit.
- `digit_en`  in  2**N  per-digit enable; 0 blanks that digit.
- `load`  in  1  one-cycle strobe; captures `data`, `dp` and `digit_en` into the pending buffer.
- `pending`  out  1  high while a captured frame waits for the next frame boundary.
- `sel`  out  N  digit index to the anode decoder's `in`.
- `sel_en`  out  1  to the anode decoder's `enable`.
- `seg`  out  7  segments gfedcba; active-low.
- `seg_dp`  out  1  decimal point; active-low.
- `frame_start`  out  1  one-cycle pulse at the start of slot 0.

## Operation
- Internal state:
  - `tick`: 0..PRESCALE-1, width $clog2(PRESCALE).
  - `idx`: N bits.
  - Pending buffer and pending flag.
  - Active buffer (data/dp/enable).
- Every cycle `tick` increments. On `tick==PRESCALE-1`, `tick` returns to 0 and `idx` increments, wrapping from 2**N-1 to 0.
- Frame boundary is the cycle where `tick==PRESCALE-1` and `idx==2**N-1`.
  - On the boundary, the active buffer takes the pending buffer if the pending flag is set, and the pending flag clears.
  - If `load` is high in the boundary cycle, the active buffer takes the inputs directly and the pending flag stays clear.
- `load` outside the boundary overwrites the pending buffer and sets the flag. Last load before the boundary wins.
- Per-slot phases:
  - BLANK phase (`tick < BLANK`): `sel_en=0`, `seg=7'h7F`, `seg_dp=1`.
  - SHOW phase: `sel_en = active digit_en[idx]`, `seg = encode(active nibble[idx])` when enabled, else 7'h7F. `seg_dp = ~(dp[idx] & digit_en[idx])`.
- `sel = idx` in both phases.
- Encoding, active-low gfedcba: 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19, 5→0x12, 6→0x02, 7→0x78, 8→0x00, 9→0x10, A→0x08, b→0x03, C→0x46, d→0x21, E→0x06, F→0x0E.

## Timing
- All outputs are registered. They reflect the internal (`tick`, `idx`, active buffer) state of the previous cycle, so output latency is 1 cycle.
- Reset values:
  - `sel=0`, `sel_en=0`, `seg=7'h7F`, `seg_dp=1`, `frame_start=0`, `pending=0`.
  - Active and pending buffers are all 0, so all digits are disabled and the display stays dark until the first load reaches the active buffer.
  - `tick=0`, `idx=0`.
- `frame_start` is high in the cycle after internal `tick==0 && idx==0`. Its first assertion is at the first clock edge after reset release, then every 2**N·PRESCALE cycles.
- A load reaches the outputs at the first frame boundary after it. Worst case is 2**N·PRESCALE+1 cycles.
- `pending` rises in the cycle after a non-boundary `load` and falls in the cycle after the boundary.
- If `BLANK=0`, there is no blank phase and `sel_en` can be high continuously across slots.
- Asserting `rst_n` mid-frame forces all outputs to their reset values immediately, without waiting for a clock. Any pending frame is discarded.

## Structure
- Shared package `seg7_pkg`:
  - 16-entry segment encoding constants.
  - Blank pattern `SEG_OFF = 7'h7F`.
- Combinational sub-module `seg7_encode`: 4-bit nibble in, 7-bit active-low segments out, built from the package constants.
- `seg7_scan_driver` contains the counters, buffers and output registers. Its `sel`/`sel_en` outputs connect directly to the existing anode decoder.

## Test plan
Bench parameters for all scenarios: N=3, PRESCALE=8, BLANK=2.
- **Reset:** hold `rst_n=0` for 5 cycles with `load=1` and arbitrary data → `seg=0x7F`, `sel_en=0`, `pending=0`. `frame_start` pulses 1 cycle after release, then every 64 cycles.
- **Scan order:** load `data=32'h76543210`, `digit_en=8'hFF`, `dp=8'h01` → after the next boundary:
  - slot k shows `sel=k`;
  - `sel_en` is low for 2 cycles, then high for 6;
  - `seg` for slots 0..3 is 0x40, 0x79, 0x24, 0x30;
  - `seg_dp=0` only in slot 0.
- **Double buffering:** load 0x11111111 mid-frame, then 0x22222222 one slot later → `pending=1` until the boundary. The next frame shows only 0x24; the value 0x79 never appears.
- **Boundary load:** `load` exactly in the boundary cycle with 0xFFFFFFFF → the next frame shows 0x0E on every digit, and `pending` stays 0.
- **Digit disable:** `digit_en=8'b1010_1010` → slots 0, 2, 4, 6 have `sel_en=0`, `seg=0x7F`, `seg_dp=1` for all 8 cycles of the slot.
- **Async reset mid-frame:** assert `rst_n` low mid-slot 5 → outputs reach their reset values before the next clock edge. After release the scan restarts at `sel=0` with a dark display.
